// File: rtl/flit_tracker_pkg.sv
// Shared types and helpers for the multi-channel flit address tracker.
// Channel-index width is derived here so every file sizes channels the same way.
package flit_tracker_pkg;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_CH_WIDTH   = ch_width(DEF_NUM_CH);

  typedef struct packed {
    logic [DEF_CH_WIDTH-1:0]   ch;
    logic [DEF_ADDR_WIDTH-1:0] address;
    logic                      head;
    logic                      tail;
  } route_rec_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ZERO_LEN,
    ERR_BAD_CH
  } err_code_t;

endpackage

// File: rtl/channel_len_counter.sv
// Per-channel packet state: flits remaining after the head and the latched address.
// A flush in the same cycle as a load or decrement always leaves the count at zero.
module channel_len_counter #(
  parameter int LEN_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  dec,
  input  logic                  flush,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  busy,
  output logic                  is_last,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [LEN_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      addr <= '0;
    end else begin
      if (load) addr <= load_addr;
      // Lengths 0 and 1 are complete in the head flit, so nothing remains
      if (flush)
        cnt <= '0;
      else if (load)
        cnt <= (load_len > LEN_WIDTH'(1)) ? load_len - LEN_WIDTH'(1) : '0;
      else if (dec)
        cnt <= cnt - LEN_WIDTH'(1);
    end
  end

  assign busy    = (cnt != '0);
  assign is_last = (cnt == LEN_WIDTH'(1));

endmodule

// File: rtl/flit_address_tracker.sv
// Tags each accepted flit with its channel's destination address and head/tail
// markers, presenting the record through a one-deep registered valid/ready stage.
module flit_address_tracker
  import flit_tracker_pkg::*;
#(
  parameter  int LEN_WIDTH  = 8,
  parameter  int ADDR_WIDTH = 8,
  parameter  int NUM_CH     = 4,
  localparam int CH_WIDTH   = ch_width(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flit_valid,
  output logic                  flit_ready,
  input  logic [CH_WIDTH-1:0]   flit_ch,
  input  logic [LEN_WIDTH-1:0]  flit_length,
  input  logic [ADDR_WIDTH-1:0] flit_address,
  input  logic                  flush_valid,
  input  logic [CH_WIDTH-1:0]   flush_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_WIDTH-1:0]   out_ch,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic                  out_head,
  output logic                  out_tail,
  output logic [NUM_CH-1:0]     ch_busy,
  output logic                  err_pulse
);

  logic                  accept;
  logic                  flit_ch_ok;
  logic                  flush_ch_ok;
  logic [NUM_CH-1:0]     busy;
  logic [NUM_CH-1:0]     last;
  logic [ADDR_WIDTH-1:0] ch_addr [NUM_CH];
  logic                  sel_busy;
  logic                  sel_last;
  logic [ADDR_WIDTH-1:0] sel_addr;
  err_code_t             err_code;

  assign flit_ready  = !out_valid || out_ready;
  assign accept      = flit_valid && flit_ready;
  assign flit_ch_ok  = (int'(flit_ch) < NUM_CH);
  assign flush_ch_ok = (int'(flush_ch) < NUM_CH);
  assign ch_busy     = busy;

  // An out-of-range channel matches no instance, so a dropped flit touches no state
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = accept && (flit_ch == CH_WIDTH'(i));

    channel_len_counter #(
      .LEN_WIDTH  (LEN_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (hit && !busy[i]),
      .dec       (hit && busy[i]),
      .flush     (flush_valid && (flush_ch == CH_WIDTH'(i))),
      .load_len  (flit_length),
      .load_addr (flit_address),
      .busy      (busy[i]),
      .is_last   (last[i]),
      .addr      (ch_addr[i])
    );
  end

  always_comb begin
    sel_busy = 1'b0;
    sel_last = 1'b0;
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (flit_ch == CH_WIDTH'(i)) begin
        sel_busy = busy[i];
        sel_last = last[i];
        sel_addr = ch_addr[i];
      end
    end
  end

  always_comb begin
    err_code = ERR_NONE;
    if (accept && !flit_ch_ok)
      err_code = ERR_BAD_CH;
    else if (accept && !sel_busy && (flit_length == '0))
      err_code = ERR_ZERO_LEN;
    else if (flush_valid && !flush_ch_ok)
      err_code = ERR_BAD_CH;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_address <= '0;
      out_head    <= 1'b0;
      out_tail    <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      err_pulse <= (err_code != ERR_NONE);
      if (accept && flit_ch_ok) begin
        out_valid   <= 1'b1;
        out_ch      <= flit_ch;
        out_head    <= !sel_busy;
        out_address <= sel_busy ? sel_addr : flit_address;
        out_tail    <= sel_busy ? sel_last : (flit_length <= LEN_WIDTH'(1));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/flit_address_tracker.md
Name: flit_address_tracker

Overview:
Multi-channel successor to the single-stream flit address counter. It tracks packet boundaries independently on NUM_CH virtual channels and latches each packet's destination address from its head flit. Every accepted flit is tagged with its channel's current address and head/tail markers, then sent to the router stage through a one-deep registered valid/ready output. It adds features the single-stream counter lacks: per-channel state, backpressure, per-channel flush, and error flagging.

Parameters:
LEN_WIDTH, 8, width of the packet-length field (total flits including head).
ADDR_WIDTH, 8, width of the destination-address field.
NUM_CH, 4, number of virtual channels (≥1, need not be a power of 2).
CH_WIDTH, $clog2(NUM_CH) (min 1), derived width of the channel index.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
flit_valid  in  1  upstream flit present
flit_ready  out  1  tracker can accept a flit this cycle
flit_ch  in  CH_WIDTH  channel of the incoming flit
flit_length  in  LEN_WIDTH  length field; meaningful only on head flits
flit_address  in  ADDR_WIDTH  address field; meaningful only on head flits
flush_valid  in  1  abort the packet in progress on flush_ch
flush_ch  in  CH_WIDTH  channel to flush
out_valid  out  1  route record valid
out_ready  in  1  downstream accepts the record
out_ch  out  CH_WIDTH  channel of the record
out_address  out  ADDR_WIDTH  destination address for this flit
out_head  out  1  flit is a packet head
out_tail  out  1  flit is a packet tail
ch_busy  out  NUM_CH  bit i set while channel i is mid-packet (cnt[i]≠0)
err_pulse  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset: when reset=0 at a clk edge, the following clear on that edge: all cnt[i], all addr[i], out_valid, out_ch, out_address, out_head, out_tail, and err_pulse. Reset overrides every other event, including mid-packet.
- Per-channel state: cnt[i] (LEN_WIDTH) holds the flits remaining after the head; addr[i] (ADDR_WIDTH) holds the latched address.
- flit_ready = !out_valid || out_ready. Accept = flit_valid && flit_ready.
- Output register: out_valid is set on accept. It clears when out_ready=1 and no new accept occurs in the same cycle. out_* hold stable while out_valid && !out_ready.
- Latency: an accepted flit's record appears on the next cycle. Throughput is one flit per cycle while out_ready=1.
- Head flit (accept with cnt[ch]==0):
  - out_head=1 and out_address=flit_address (bypass); addr[ch] is loaded with flit_address.
  - flit_length≥2: cnt[ch] <= flit_length-1, out_tail=0.
  - flit_length==1: single-flit packet. out_tail=1 and cnt stays 0.
  - flit_length==0: forward as head+tail, cnt stays 0, and assert err_pulse the following cycle.
- Body flit (accept with cnt[ch]≠0):
  - out_head=0, out_address=addr[ch], cnt[ch] <= cnt[ch]-1.
  - out_tail=1 iff cnt[ch]==1. flit_length and flit_address are ignored.
- Out-of-range channel (flit_ch ≥ NUM_CH): the flit is accepted and dropped. No record is produced, no state changes, and err_pulse fires the next cycle. The same applies to flush_ch ≥ NUM_CH: ignored, with err_pulse.
- Flush:
  - flush_valid sets cnt[flush_ch] to 0 on the next edge. addr is unchanged.
  - If the same cycle accepts a flit on the same channel, the record is still produced as computed from pre-flush state. The flush then wins the cnt update (cnt=0 even if a head loaded length≥2).
  - Flush on an idle channel is a no-op with no error.
- Only one channel's cnt/addr changes per flit accept. A flush on a different channel proceeds independently in the same cycle.
- Arithmetic: unsigned, LEN_WIDTH-wide. Decrement never wraps, because it only occurs when cnt≠0.
- ch_busy is combinational from the cnt registers.

Decomposition:
- Package flit_tracker_pkg:
  - route_rec_t struct {ch, address, head, tail};
  - localparam helpers for CH_WIDTH;
  - err code enum {ERR_NONE, ERR_ZERO_LEN, ERR_BAD_CH} (internal; only the pulse is exported).
- Sub-module channel_len_counter (one per channel via generate):
  - holds cnt and addr;
  - inputs load/dec/flush/len/addr;
  - outputs busy, is_last, addr;
  - built on the existing register module.
- The top level holds accept logic, the channel mux and the output register.

Test Plan:
- Head ch1 len=3 addr=0x5A, then 2 body flits ch1 (out_ready=1) -> records (head,0x5A), (body,0x5A), (tail,0x5A) on consecutive cycles; ch_busy[1] set for 2 cycles after head.
- Interleave ch0 head len=2 addr=0x11 and ch2 head len=2 addr=0x22, then ch2 body, then ch0 body -> tails carry 0x22 then 0x11; channels do not corrupt each other's state.
- Hold out_ready=0 with a record pending, drive flit_valid -> flit_ready=0, out_* stable, cnt unchanged; release -> flit accepted the cycle out_ready rises.
- Head len=1 addr=0x7 on ch3 -> single record head=1, tail=1, ch_busy[3]=0. Head len=0 -> head+tail record plus err_pulse for exactly 1 cycle.
- ch1 mid-packet (cnt=4), assert flush ch1 together with a ch1 body accept -> body record emitted with old addr, then cnt=0; next ch1 flit is treated as head.
- Drive reset=0 for one edge with ch0 at cnt=5 and out_valid=1 -> all outputs 0, ch_busy=0; with NUM_CH=3, flit_ch=3 -> no record, err_pulse.
